// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register feeding the execute ALU.
//   - Captures a decoded instruction under a valid/ready handshake.
//   - Resolves EX/MEM and MEM/WB operand forwarding combinationally and drives
//     the ALU operands in1/in2 and the registered opcode aluOperation.
//   - Detects load-use hazards and inserts a single bubble.
//   - A branch flush kills both the held and the offered instruction.
//
// Ports
//   clk, resetN                 clock, async active-low reset
//   inValid / inReady           decode handshake (inReady is combinational)
//   inPc, inRs1Data, inRs2Data  decoded PC and register-file operands
//   inRs1Addr, inRs2Addr        source register indices
//   inRdAddr, inImm, inUseImm   destination, immediate, immediate select
//   inAluOperation              ALU opcode (ADD = 4'b0000)
//   inIsLoad, inRegWrite        instruction class / writes rd
//   exMem*, memWb*              forwarding sources from later stages
//   flush                       branch taken, kill held and offered instr
//   outValid / outReady         downstream handshake
//   in1, in2, aluOperation      ALU operands (forwarded) and opcode
//   outStoreData                forwarded rs2 value
//   outPc, outRdAddr,
//   outIsLoad, outRegWrite      registered copies of the held instruction
//
// Configuration
//   ID_EX_PERF_COUNT_EN  when defined, adds bubbleCount[31:0]: number of
//                        load-use bubble edges since reset (wraps, not cleared
//                        by flush).
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [XLEN-1:0]       inPc,
  input  logic [XLEN-1:0]       inRs1Data,
  input  logic [XLEN-1:0]       inRs2Data,
  input  logic [REG_ADDR_W-1:0] inRs1Addr,
  input  logic [REG_ADDR_W-1:0] inRs2Addr,
  input  logic [REG_ADDR_W-1:0] inRdAddr,
  input  logic [XLEN-1:0]       inImm,
  input  logic                  inUseImm,
  input  logic [3:0]            inAluOperation,
  input  logic                  inIsLoad,
  input  logic                  inRegWrite,
  input  logic                  exMemRegWrite,
  input  logic [REG_ADDR_W-1:0] exMemRdAddr,
  input  logic [XLEN-1:0]       exMemAluOutput,
  input  logic                  memWbRegWrite,
  input  logic [REG_ADDR_W-1:0] memWbRdAddr,
  input  logic [XLEN-1:0]       memWbWriteData,
  input  logic                  flush,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [XLEN-1:0]       in1,
  output logic [XLEN-1:0]       in2,
  output logic [3:0]            aluOperation,
  output logic [XLEN-1:0]       outStoreData,
  output logic [XLEN-1:0]       outPc,
  output logic [REG_ADDR_W-1:0] outRdAddr,
  output logic                  outIsLoad,
  output logic                  outRegWrite
`ifdef ID_EX_PERF_COUNT_EN
  ,
  output logic [31:0]           bubbleCount
`endif
);

  localparam logic [3:0]            ALU_ADD  = 4'b0000;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};

  // A producer matches a source when it writes a non-x0 rd equal to that source.
  function automatic logic fwd_hit(input logic                  we,
                                   input logic [REG_ADDR_W-1:0] rd,
                                   input logic [REG_ADDR_W-1:0] rs);
    return we & (rd != REG_ZERO) & (rd == rs);
  endfunction

  logic                  valid_q,     valid_d;
  logic [XLEN-1:0]       pc_q,        pc_d;
  logic [REG_ADDR_W-1:0] rs1_addr_q,  rs1_addr_d;
  logic [REG_ADDR_W-1:0] rs2_addr_q,  rs2_addr_d;
  logic [REG_ADDR_W-1:0] rd_addr_q,   rd_addr_d;
  logic [XLEN-1:0]       rs1_data_q,  rs1_data_d;
  logic [XLEN-1:0]       rs2_data_q,  rs2_data_d;
  logic [XLEN-1:0]       imm_q,       imm_d;
  logic                  use_imm_q,   use_imm_d;
  logic [3:0]            alu_op_q,    alu_op_d;
  logic                  is_load_q,   is_load_d;
  logic                  reg_write_q, reg_write_d;

  logic            load_use_s;
  logic            in_ready_s;
  logic            capture_s;
  logic            bubble_s;
  logic [XLEN-1:0] fwd_rs1_s;
  logic [XLEN-1:0] fwd_rs2_s;
  logic [XLEN-1:0] cap_rs1_s;
  logic [XLEN-1:0] cap_rs2_s;

  // Hazard detection and handshake: a held load stalls any consumer of its rd.
  always_comb begin
    load_use_s = valid_q & is_load_q & reg_write_q & (rd_addr_q != REG_ZERO) &
                 ((rd_addr_q == inRs1Addr) | (rd_addr_q == inRs2Addr));
    in_ready_s = ~load_use_s & (~valid_q | outReady);
    capture_s  = inValid & in_ready_s;
    // capture is impossible while load_use_s is set, so only flush outranks it
    bubble_s   = ~flush & load_use_s & outReady;
  end

  // Operand forwarding for the held instruction: EX/MEM is younger, so it wins.
  always_comb begin
    fwd_rs1_s = rs1_data_q;
    fwd_rs2_s = rs2_data_q;
    if (fwd_hit(exMemRegWrite, exMemRdAddr, rs1_addr_q)) begin
      fwd_rs1_s = exMemAluOutput;
    end else if (fwd_hit(memWbRegWrite, memWbRdAddr, rs1_addr_q)) begin
      fwd_rs1_s = memWbWriteData;
    end else begin
      fwd_rs1_s = rs1_data_q;
    end
    if (fwd_hit(exMemRegWrite, exMemRdAddr, rs2_addr_q)) begin
      fwd_rs2_s = exMemAluOutput;
    end else if (fwd_hit(memWbRegWrite, memWbRdAddr, rs2_addr_q)) begin
      fwd_rs2_s = memWbWriteData;
    end else begin
      fwd_rs2_s = rs2_data_q;
    end
  end

  // Capture-time bypass: the register file has not yet seen the MEM/WB write.
  always_comb begin
    cap_rs1_s = inRs1Data;
    cap_rs2_s = inRs2Data;
    if (fwd_hit(memWbRegWrite, memWbRdAddr, inRs1Addr)) begin
      cap_rs1_s = memWbWriteData;
    end else begin
      cap_rs1_s = inRs1Data;
    end
    if (fwd_hit(memWbRegWrite, memWbRdAddr, inRs2Addr)) begin
      cap_rs2_s = memWbWriteData;
    end else begin
      cap_rs2_s = inRs2Data;
    end
  end

  // Next-state selection with priority flush > capture > bubble > advance > hold.
  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    rd_addr_d   = rd_addr_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    use_imm_d   = use_imm_q;
    alu_op_d    = alu_op_q;
    is_load_d   = is_load_q;
    reg_write_d = reg_write_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture_s) begin
      valid_d     = 1'b1;
      pc_d        = inPc;
      rs1_addr_d  = inRs1Addr;
      rs2_addr_d  = inRs2Addr;
      rd_addr_d   = inRdAddr;
      rs1_data_d  = cap_rs1_s;
      rs2_data_d  = cap_rs2_s;
      imm_d       = inImm;
      use_imm_d   = inUseImm;
      alu_op_d    = inAluOperation;
      is_load_d   = inIsLoad;
      reg_write_d = inRegWrite;
    end else if (bubble_s) begin
      valid_d = 1'b0;
    end else if (outReady) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      // stalled: latch forwarded values so they survive the producer retiring
      rs1_data_d = fwd_rs1_s;
      rs2_data_d = fwd_rs2_s;
    end else begin
      valid_d = valid_q;
    end
  end

  // Pipeline register bank.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      valid_q     <= 1'b0;
      pc_q        <= {XLEN{1'b0}};
      rs1_addr_q  <= REG_ZERO;
      rs2_addr_q  <= REG_ZERO;
      rd_addr_q   <= REG_ZERO;
      rs1_data_q  <= {XLEN{1'b0}};
      rs2_data_q  <= {XLEN{1'b0}};
      imm_q       <= {XLEN{1'b0}};
      use_imm_q   <= 1'b0;
      alu_op_q    <= ALU_ADD;
      is_load_q   <= 1'b0;
      reg_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rd_addr_q   <= rd_addr_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      use_imm_q   <= use_imm_d;
      alu_op_q    <= alu_op_d;
      is_load_q   <= is_load_d;
      reg_write_q <= reg_write_d;
    end
  end

`ifdef ID_EX_PERF_COUNT_EN
  logic [31:0] bubble_count_q, bubble_count_d;

  // Bubble counter next value; wraps naturally at 2^32.
  always_comb begin
    if (bubble_s) begin
      bubble_count_d = bubble_count_q + 32'd1;
    end else begin
      bubble_count_d = bubble_count_q;
    end
  end

  // Bubble counter register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bubble_count_q <= 32'd0;
    end else begin
      bubble_count_q <= bubble_count_d;
    end
  end

  assign bubbleCount = bubble_count_q;
`endif

  assign inReady      = in_ready_s;
  assign outValid     = valid_q;
  assign in1          = fwd_rs1_s;
  assign in2          = use_imm_q ? imm_q : fwd_rs2_s;
  assign outStoreData = fwd_rs2_s;
  assign aluOperation = alu_op_q;
  assign outPc        = pc_q;
  assign outRdAddr    = rd_addr_q;
  assign outIsLoad    = is_load_q;
  assign outRegWrite  = reg_write_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Scoreboard bench for id_ex_stage: each issued instruction pushes its expected
// ALU-side view; a negedge monitor pops and compares whenever EX hands off.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

  logic        clk;
  logic        resetN;
  logic        inValid;
  logic        inReady;
  logic [31:0] inPc, inRs1Data, inRs2Data, inImm;
  logic [4:0]  inRs1Addr, inRs2Addr, inRdAddr;
  logic        inUseImm;
  logic [3:0]  inAluOperation;
  logic        inIsLoad, inRegWrite;
  logic        exMemRegWrite;
  logic [4:0]  exMemRdAddr;
  logic [31:0] exMemAluOutput;
  logic        memWbRegWrite;
  logic [4:0]  memWbRdAddr;
  logic [31:0] memWbWriteData;
  logic        flush;
  logic        outValid;
  logic        outReady;
  logic [31:0] in1, in2, outStoreData, outPc;
  logic [3:0]  aluOperation;
  logic [4:0]  outRdAddr;
  logic        outIsLoad, outRegWrite;
`ifdef ID_EX_PERF_COUNT_EN
  logic [31:0] bubbleCount;
`endif

  id_ex_stage dut (
    .clk(clk), .resetN(resetN),
    .inValid(inValid), .inReady(inReady),
    .inPc(inPc), .inRs1Data(inRs1Data), .inRs2Data(inRs2Data),
    .inRs1Addr(inRs1Addr), .inRs2Addr(inRs2Addr), .inRdAddr(inRdAddr),
    .inImm(inImm), .inUseImm(inUseImm), .inAluOperation(inAluOperation),
    .inIsLoad(inIsLoad), .inRegWrite(inRegWrite),
    .exMemRegWrite(exMemRegWrite), .exMemRdAddr(exMemRdAddr),
    .exMemAluOutput(exMemAluOutput),
    .memWbRegWrite(memWbRegWrite), .memWbRdAddr(memWbRdAddr),
    .memWbWriteData(memWbWriteData),
    .flush(flush), .outValid(outValid), .outReady(outReady),
    .in1(in1), .in2(in2), .aluOperation(aluOperation),
    .outStoreData(outStoreData), .outPc(outPc), .outRdAddr(outRdAddr),
    .outIsLoad(outIsLoad), .outRegWrite(outRegWrite)
`ifdef ID_EX_PERF_COUNT_EN
    , .bubbleCount(bubbleCount)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] sd;
    logic [3:0]  op;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count a comparison and report a mismatch.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_fwd();
    exMemRegWrite  = 1'b0; exMemRdAddr = 5'd0; exMemAluOutput = 32'd0;
    memWbRegWrite  = 1'b0; memWbRdAddr = 5'd0; memWbWriteData = 32'd0;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [4:0] r1, input logic [31:0] d1,
                       input logic [4:0] r2, input logic [31:0] d2, input logic [4:0] rd,
                       input logic [31:0] imm, input logic ui, input logic [3:0] op,
                       input logic ld, input logic rw);
    inPc = pc; inRs1Addr = r1; inRs1Data = d1; inRs2Addr = r2; inRs2Data = d2;
    inRdAddr = rd; inImm = imm; inUseImm = ui; inAluOperation = op;
    inIsLoad = ld; inRegWrite = rw; inValid = 1'b1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] sd, input logic [3:0] op, input logic [4:0] rd);
    exp_t e;
    e.pc = pc; e.op1 = a; e.op2 = b; e.sd = sd; e.op = op; e.rd = rd;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: an instruction leaves EX when outValid & outReady.
  always @(negedge clk) begin
    if (resetN && outValid && outReady) begin
      check_eq("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check_eq("out_pc",  outPc,                 mon_e.pc);
        check_eq("in1",     in1,                   mon_e.op1);
        check_eq("in2",     in2,                   mon_e.op2);
        check_eq("store",   outStoreData,          mon_e.sd);
        check_eq("alu_op",  32'(aluOperation),     32'(mon_e.op));
        check_eq("out_rd",  32'(outRdAddr),        32'(mon_e.rd));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN = 1'b0; flush = 1'b0; outReady = 1'b1; inValid = 1'b0;
    inPc = 32'd0; inRs1Data = 32'd0; inRs2Data = 32'd0; inImm = 32'd0;
    inRs1Addr = 5'd0; inRs2Addr = 5'd0; inRdAddr = 5'd0; inUseImm = 1'b0;
    inAluOperation = 4'd0; inIsLoad = 1'b0; inRegWrite = 1'b0;
    clr_fwd();

    // Reset state
    @(negedge clk);
    check_eq("rst_valid",  32'(outValid),     32'd0);
    check_eq("rst_op",     32'(aluOperation), 32'd0);
    check_eq("rst_pc",     outPc,             32'd0);
    check_eq("rst_ready",  32'(inReady),      32'd1);
`ifdef ID_EX_PERF_COUNT_EN
    check_eq("rst_bcnt",   bubbleCount,       32'd0);
`endif
    tick();
    resetN = 1'b1;
    tick();

    // ADD x3,x1,x2 with x1=5, x2=7
    drive(32'h100, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 32'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    push(32'h100, 32'd5, 32'd7, 32'd7, 4'd0, 5'd3);
    tick();
    inValid = 1'b0;
    @(negedge clk);
    check_eq("add_valid", 32'(outValid), 32'd1);
    tick();
    @(negedge clk);
    check_eq("add_drain", 32'(outValid), 32'd0);

    // EX/MEM forwards x1=0x10 over stale regfile value
    tick();
    drive(32'h200, 5'd1, 32'hAA, 5'd4, 32'd3, 5'd6, 32'd0, 1'b0, 4'd1, 1'b0, 1'b1);
    exMemRegWrite = 1'b1; exMemRdAddr = 5'd1; exMemAluOutput = 32'h10;
    push(32'h200, 32'h10, 32'd3, 32'd3, 4'd1, 5'd6);
    tick();
    inValid = 1'b0;
    tick();
    // Same rd in both producers: EX/MEM must win
    drive(32'h204, 5'd1, 32'hAA, 5'd4, 32'd3, 5'd6, 32'd0, 1'b0, 4'd2, 1'b0, 1'b1);
    exMemRegWrite = 1'b1; exMemRdAddr = 5'd1; exMemAluOutput = 32'h10;
    memWbRegWrite = 1'b1; memWbRdAddr = 5'd1; memWbWriteData = 32'h20;
    push(32'h204, 32'h10, 32'd3, 32'd3, 4'd2, 5'd6);
    tick();
    inValid = 1'b0;
    tick();
    clr_fwd();
    // MEM/WB forwarding applied after capture, immediate selects in2
    drive(32'h208, 5'd8, 32'd1, 5'd7, 32'h70, 5'd9, 32'hFFFF_FFF0, 1'b1, 4'd3, 1'b0, 1'b1);
    push(32'h208, 32'd1, 32'hFFFF_FFF0, 32'h77, 4'd3, 5'd9);
    tick();
    inValid = 1'b0;
    memWbRegWrite = 1'b1; memWbRdAddr = 5'd7; memWbWriteData = 32'h77;
    tick();
    clr_fwd();

    // Load-use: LW x5 then consumer of x5
    drive(32'h300, 5'd2, 32'h1000, 5'd0, 32'd0, 5'd5, 32'd4, 1'b1, 4'd0, 1'b1, 1'b1);
    push(32'h300, 32'h1000, 32'd4, 32'd0, 4'd0, 5'd5);
    tick();
    drive(32'h304, 5'd6, 32'd1, 5'd5, 32'hBAD, 5'd7, 32'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    push(32'h304, 32'd1, 32'hDEAD, 32'hDEAD, 4'd0, 5'd7);
    @(negedge clk);
    check_eq("lu_stall", 32'(inReady), 32'd0);
    tick();
    @(negedge clk);
    check_eq("lu_bubble", 32'(outValid), 32'd0);
    check_eq("lu_ready",  32'(inReady),  32'd1);
    memWbRegWrite = 1'b1; memWbRdAddr = 5'd5; memWbWriteData = 32'hDEAD;
    tick();
    inValid = 1'b0;
    clr_fwd();
    @(negedge clk);
    check_eq("lu_capt", 32'(outValid), 32'd1);
`ifdef ID_EX_PERF_COUNT_EN
    check_eq("lu_bcnt", bubbleCount, 32'd1);
`endif
    tick();

    // Stall 3 cycles while MEM/WB writes rs1=0x55, then producer retires
    drive(32'h400, 5'd8, 32'd1, 5'd9, 32'd2, 5'd10, 32'd0, 1'b0, 4'd4, 1'b0, 1'b1);
    push(32'h400, 32'h55, 32'd2, 32'd2, 4'd4, 5'd10);
    tick();
    drive(32'h404, 5'd11, 32'd0, 5'd12, 32'd0, 5'd13, 32'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    outReady = 1'b0;
    memWbRegWrite = 1'b1; memWbRdAddr = 5'd8; memWbWriteData = 32'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("hold_valid", 32'(outValid),  32'd1);
      check_eq("hold_pc",    outPc,          32'h400);
      check_eq("hold_rd",    32'(outRdAddr), 32'd10);
      check_eq("hold_ready", 32'(inReady),   32'd0);
      check_eq("hold_in1",   in1,            32'h55);
      tick();
    end
    inValid = 1'b0;
    clr_fwd();
    outReady = 1'b1;
    tick();

    // Flush kills held and offered instructions
    outReady = 1'b0;
    drive(32'h500, 5'd1, 32'd1, 5'd2, 32'd2, 5'd3, 32'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    tick();
    drive(32'h504, 5'd1, 32'd1, 5'd2, 32'd2, 5'd3, 32'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    check_eq("fl_before", 32'(outValid), 32'd1);
    tick();
    flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
    @(negedge clk);
    check_eq("fl_killed", 32'(outValid), 32'd0);
    tick();
    @(negedge clk);
    check_eq("fl_empty", 32'(outValid), 32'd0);
    tick();

    // x0 is never forwarded
    drive(32'h600, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1, 32'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    exMemRegWrite = 1'b1; exMemRdAddr = 5'd0; exMemAluOutput = 32'hFF;
    memWbRegWrite = 1'b1; memWbRdAddr = 5'd0; memWbWriteData = 32'hEE;
    push(32'h600, 32'd0, 32'd0, 32'd0, 4'd0, 5'd1);
    tick();
    inValid = 1'b0;
    tick();
    clr_fwd();

    // Async reset mid-stream
    outReady = 1'b0;
    drive(32'h700, 5'd1, 32'd9, 5'd2, 32'd9, 5'd3, 32'd0, 1'b0, 4'd5, 1'b0, 1'b1);
    tick();
    inValid = 1'b0;
    #2;
    resetN = 1'b0;
    #1;
    check_eq("ar_valid", 32'(outValid),     32'd0);
    check_eq("ar_pc",    outPc,             32'd0);
    check_eq("ar_op",    32'(aluOperation), 32'd0);
`ifdef ID_EX_PERF_COUNT_EN
    check_eq("ar_bcnt",  bubbleCount,       32'd0);
`endif
    tick();
    resetN = 1'b1; outReady = 1'b1;
    @(negedge clk);
    check_eq("ar_idle", 32'(outValid), 32'd0);
    tick();
    drive(32'h800, 5'd3, 32'h33, 5'd4, 32'h44, 5'd5, 32'd0, 1'b0, 4'd6, 1'b0, 1'b1);
    push(32'h800, 32'h33, 32'h44, 32'h44, 4'd6, 5'd5);
    tick();
    inValid = 1'b0;
    tick();
    tick();

    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
